conf_bus_loader_64: RTL and testbench
=====================================

# conf_bus_loader_64

Upstream feeder for the switch/PE configuration readers of the CGRA. It accepts a counted stream of 64-bit configuration words from the host over a valid/ready handshake, buffers them, and broadcasts them one per cycle on the shared `conf_bus_in` net of every `swicth_conf_control_*` / PE control block. It then waits for the readers' pipelines to settle and raises `en_pc_net` to start the per-thread program counters. It owns the configure → run sequencing of the array.

## Interface
- `FIFO_DEPTH`, 4: input buffer entries; power of two, minimum 2.
- `DRAIN_CYCLES`, 4: idle bus cycles after the last word before `en_pc_net` rises; minimum 1.
- `CNT_WIDTH`, 16: width of the word counters.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous and active-high: sampled only on the rising edge of `clk`.
- `start`  in  1  single-cycle pulse that begins a configuration load.
- `num_words`  in  CNT_WIDTH  number of words in the load; sampled when `start` is accepted.
- `stop`  in  1  single-cycle pulse that ends RUN.
- `in_valid`  in  1  host word valid.
- `in_data`  in  64  host configuration word.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `conf_bus_out`  out  64  registered broadcast word. Drive it to `conf_bus_in` of all readers.
- `en_pc_net`  out  1  program-counter / thread-counter enable to all control blocks.
- `busy`  out  1  high in LOAD or DRAIN.
- `done`  out  1  one-cycle pulse on entry to RUN.

## Operation
- Bus word format: bit 63 is the valid flag. An all-zero bus word is a NOP and readers ignore it. The block forces bit 63 = 1 on every word it emits; bits 62:0 pass through unchanged.
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE:
  - `start` with `num_words` > 0 goes to LOAD and latches `num_words` into `target`.
  - `start` with `num_words` = 0 goes straight to DRAIN.
- LOAD:
  - A word is accepted when `in_valid` and `in_ready` are both high.
  - `in_ready` = (state == LOAD) && FIFO not full && `acc_cnt` < `target`.
  - Each cycle the FIFO is non-empty, the head is popped into `conf_bus_out` (bit 63 forced) and `emit_cnt` increments.
  - Each cycle the FIFO is empty, `conf_bus_out` loads 0.
  - When the pop that brings `emit_cnt` to `target` occurs, the next state is DRAIN.
- DRAIN:
  - `conf_bus_out` = 0.
  - A counter runs DRAIN_CYCLES cycles, then the block enters RUN.
- RUN:
  - `en_pc_net` = 1 and `conf_bus_out` = 0.
  - `stop` goes to IDLE.
  - `start` re-enters LOAD (or DRAIN when `num_words` = 0), with the same rules as IDLE.
  - `start` and `stop` in the same cycle: `start` wins.
- Ignored inputs:
  - `start` in LOAD or DRAIN.
  - `stop` outside RUN.
  - `in_valid` outside LOAD; `in_ready` stays 0.
- Counters:
  - `acc_cnt` and `emit_cnt` are CNT_WIDTH bits and are cleared on every accepted `start`.
  - The maximum load is 2^CNT_WIDTH−1 words. Neither counter wraps.
- A FIFO push and pop in the same cycle are legal when the FIFO is full: occupancy is unchanged.

## Timing
- Reset values:
  - state = IDLE.
  - FIFO emptied; all counters = 0.
  - `conf_bus_out` = 0, `en_pc_net` = 0, `in_ready` = 0, `busy` = 0, `done` = 0.
- `rst` asserted mid-LOAD or mid-RUN discards buffered words. `en_pc_net` drops on the edge after `rst`.
- Latency:
  - A word accepted on edge k is stored in the FIFO at edge k.
  - It is popped and registered onto `conf_bus_out` at edge k+1 at the earliest.
  - Throughput is 1 word per cycle when the host streams continuously.
- Sequencing after the last bus word:
  - The last word is visible for exactly one cycle.
  - Then exactly DRAIN_CYCLES cycles of 0 follow.
  - Then `en_pc_net` = 1 and `done` = 1 on the same cycle.
- `en_pc_net` falls on the edge after an accepted `stop` or `start`. It is never high while `busy` = 1.
- `in_ready` is combinational from state, FIFO full and `acc_cnt`. It does not depend on `in_valid`.

## Structure
- Shared package `conf_bus_pkg`:
  - `CONF_BUS_WIDTH` = 64.
  - `CONF_VALID_BIT` = 63.
  - `CONF_NOP` = 64'h0.
  - State typedef `conf_load_state_t` {IDLE, LOAD, DRAIN, RUN}.
- The readers use the same package so that the word format has a single definition.
- One sub-module, `conf_fifo`:
  - Synchronous FIFO, parameters WIDTH/DEPTH.
  - Outputs `full`, `empty`, `dout` (first-word-fall-through).
  - Synchronous active-high `rst`.
- The FSM, counters and output register live in the top.

## Test plan
- Reset → all outputs 0. After `start`, `num_words` = 3, host streams A, B, C back-to-back: bus shows A|bit63, B|bit63, C|bit63 on consecutive cycles, then 4 zero cycles. `en_pc_net` and `done` rise together, and `done` lasts 1 cycle.
- `num_words` = 6, host holds `in_valid` but downstream is continuous, FIFO_DEPTH = 4: exactly 6 words are accepted, with no loss and no duplicates. `in_ready` = 0 after the 6th word even though `in_valid` stays high.
- Host inserts gaps (`in_valid` low on every 2nd cycle): NOP words (0) appear on the bus in the gaps. DRAIN starts only after the 5th of `num_words` = 5 is emitted.
- `num_words` = 0 → bus stays 0. `en_pc_net` rises DRAIN_CYCLES+1 cycles after the `start` edge.
- In RUN, `start` and `stop` in the same cycle → LOAD entered and `en_pc_net` = 0 the next cycle. `stop` in DRAIN is ignored.
- `rst` pulsed after 2 of 4 words have been accepted → the next cycle `conf_bus_out` = 0 and state is IDLE. A fresh load of 1 word completes normally.

Source files
------------

// File: rtl/conf_bus_pkg.sv
// Shared definitions for the CGRA configuration bus: word format and loader states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: bus width, valid-flag bit position, NOP word, loader state encoding.
package conf_bus_pkg;

    localparam int CONF_BUS_WIDTH = 64;
    localparam int CONF_VALID_BIT = 63;
    localparam logic [CONF_BUS_WIDTH-1:0] CONF_NOP = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } conf_load_state_t;

endpackage

// File: rtl/conf_fifo.sv
// Synchronous first-word-fall-through FIFO buffering host configuration words.
// Latency: a word pushed on edge k is visible on dout after edge k, poppable at edge k+1.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/din, pop, full, empty, dout (head of queue).
module conf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy tracking alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/conf_bus_loader_64.sv
// Buffers a counted host word stream and broadcasts it on the config bus, then starts the PCs.
// Latency: word accepted on edge k reaches conf_bus_out at edge k+1 earliest; 1 word/cycle.
// Backpressure: in_ready low outside LOAD, when the FIFO is full or all words are accepted.
// Ports: clk/rst (sync, active-high); start/num_words/stop control; in_valid/in_ready/in_data
//        host stream; conf_bus_out broadcast word; en_pc_net run enable; busy; done pulse.
module conf_bus_loader_64
    import conf_bus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_WIDTH-1:0]      num_words,
    input  logic                      stop,
    input  logic                      in_valid,
    input  logic [CONF_BUS_WIDTH-1:0] in_data,
    output logic                      in_ready,
    output logic [CONF_BUS_WIDTH-1:0] conf_bus_out,
    output logic                      en_pc_net,
    output logic                      busy,
    output logic                      done
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    conf_load_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]      target_q, target_d;
    logic [CNT_WIDTH-1:0]      acc_cnt_q, acc_cnt_d;
    logic [CNT_WIDTH-1:0]      emit_cnt_q, emit_cnt_d;
    logic [DW-1:0]             drain_cnt_q, drain_cnt_d;
    logic [CONF_BUS_WIDTH-1:0] bus_q, bus_d;
    logic                      en_pc_q, en_pc_d;
    logic                      done_q, done_d;

    logic                      fifo_full, fifo_empty;
    logic [CONF_BUS_WIDTH-1:0] fifo_dout;
    logic                      push, pop;

    assign in_ready = (state_q == LOAD) && !fifo_full && (acc_cnt_q < target_q);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == LOAD) && !fifo_empty;

    conf_fifo #(
        .WIDTH (CONF_BUS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_data),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        acc_cnt_d   = acc_cnt_q;
        emit_cnt_d  = emit_cnt_q;
        drain_cnt_d = drain_cnt_q;
        bus_d       = CONF_NOP;

        case (state_q)
            IDLE, RUN: begin
                // start outranks a simultaneous stop in RUN
                if (start) begin
                    target_d    = num_words;
                    acc_cnt_d   = '0;
                    emit_cnt_d  = '0;
                    drain_cnt_d = '0;
                    state_d     = (num_words != '0) ? LOAD : DRAIN;
                end else if (state_q == RUN && stop) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (push) begin
                    acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
                end
                if (pop) begin
                    bus_d                 = fifo_dout;
                    bus_d[CONF_VALID_BIT] = 1'b1;
                    emit_cnt_d            = emit_cnt_q + CNT_WIDTH'(1);
                    if (emit_cnt_d == target_q) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                // The cycle entering DRAIN still shows the last word, hence the
                // extra count before RUN so exactly DRAIN_CYCLES NOPs follow it.
                if (drain_cnt_q == DW'(DRAIN_CYCLES)) begin
                    state_d = RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        en_pc_d = (state_d == RUN);
        done_d  = (state_q == DRAIN) && (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            acc_cnt_q   <= '0;
            emit_cnt_q  <= '0;
            drain_cnt_q <= '0;
            bus_q       <= CONF_NOP;
            en_pc_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            acc_cnt_q   <= acc_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            bus_q       <= bus_d;
            en_pc_q     <= en_pc_d;
            done_q      <= done_d;
        end
    end

    assign conf_bus_out = bus_q;
    assign en_pc_net    = en_pc_q;
    assign done         = done_q;
    assign busy         = (state_q == LOAD) || (state_q == DRAIN);

endmodule

// File: tb/tb_conf_bus_loader_64.sv
// Self-checking bench for conf_bus_loader_64: random host words against a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_conf_bus_loader_64;

    localparam int DRAIN = 4;
    localparam logic [63:0] VBIT = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_words;
    logic        stop;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [63:0] conf_bus_out;
    logic        en_pc_net;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    conf_bus_loader_64 #(
        .FIFO_DEPTH   (4),
        .DRAIN_CYCLES (DRAIN),
        .CNT_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_words    (num_words),
        .stop         (stop),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .conf_bus_out (conf_bus_out),
        .en_pc_net    (en_pc_net),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete load: start pulse, host stream, bus scoreboard, drain and run entry.
    // gap_mode 0 = continuous host, 1 = host idle every second cycle, 2 = random host.
    task automatic run_load(input int n, input int gap_mode, input bit with_stop);
        logic [63:0] exp_q[$];
        logic [63:0] word;
        int  accepted;
        int  emitted;
        int  cyc;
        int  first_cyc;
        int  last_cyc;
        int  zeros;
        bit  vld;
        bit  rdy;

        accepted  = 0;
        emitted   = 0;
        cyc       = 0;
        first_cyc = -1;
        last_cyc  = -1;

        start     = 1'b1;
        stop      = with_stop;
        num_words = 16'(n);
        step();
        start     = 1'b0;
        stop      = 1'b0;
        check("en_pc_after_start", en_pc_net, 0);
        check("busy_after_start", busy, 1);
        check("bus_after_start", conf_bus_out, 0);

        while (emitted < n && cyc < 200) begin
            case (gap_mode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            word     = {$urandom, $urandom};
            in_valid = vld;
            in_data  = word;
            rdy      = in_ready;
            // Output is drained every cycle, so the buffer never fills: ready
            // depends only on how many words remain to be accepted.
            check("in_ready_load", rdy, (accepted < n));
            step();
            cyc++;
            if (vld && rdy) begin
                accepted++;
                exp_q.push_back(word | VBIT);
            end
            check("en_pc_low_in_load", en_pc_net, 0);
            if (conf_bus_out !== 64'h0) begin
                emitted++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) check("bus_unexpected", conf_bus_out, 0);
                else check("bus_word", conf_bus_out, exp_q.pop_front());
            end
        end
        check("emitted_count", emitted, n);
        check("accepted_count", accepted, n);
        check("in_ready_after_last", in_ready, 0);
        if (n > 0 && gap_mode == 0) begin
            check("first_word_latency", first_cyc, 2);
            check("span_continuous", last_cyc - first_cyc, n - 1);
        end
        if (n > 0 && gap_mode == 1) begin
            check("first_word_latency", first_cyc, 2);
            check("span_gapped", last_cyc - first_cyc, 2 * (n - 1));
        end

        // Drain: host keeps offering, stop and start pulses must all be ignored.
        zeros = 0;
        step();
        while (!en_pc_net && zeros < 50) begin
            check("drain_bus_nop", conf_bus_out, 0);
            check("drain_busy", busy, 1);
            zeros++;
            stop      = (zeros == 1);
            start     = (zeros == 2);
            num_words = 16'd7;
            step();
        end
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
        check("drain_cycles", zeros, DRAIN);
        check("run_en_pc", en_pc_net, 1);
        check("run_done", done, 1);
        check("run_busy", busy, 0);
        check("run_bus", conf_bus_out, 0);
        step();
        check("done_one_cycle", done, 0);
        check("en_pc_held", en_pc_net, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        num_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        step();
        step();
        check("rst_bus", conf_bus_out, 0);
        check("rst_en_pc", en_pc_net, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h1234;
        step();
        check("idle_in_ready", in_ready, 0);
        check("idle_bus", conf_bus_out, 0);
        in_valid = 1'b0;

        // Three words back-to-back from IDLE.
        run_load(3, 0, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_en_pc", en_pc_net, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);

        // Six words with the host holding valid beyond the count.
        run_load(6, 0, 1'b0);
        // Gapped host, started straight from RUN.
        run_load(5, 1, 1'b0);
        // Empty load goes straight to drain.
        run_load(0, 0, 1'b0);
        // start and stop together in RUN: start wins.
        run_load(2, 0, 1'b1);

        // Reset in the middle of a 4-word load after two accepts.
        start     = 1'b1;
        num_words = 16'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        step();
        in_data  = {$urandom, $urandom};
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("midrst_bus", conf_bus_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_en_pc", en_pc_net, 0);
        run_load(1, 0, 1'b0);

        // Random loads.
        for (int i = 0; i < 4; i++) begin
            run_load(int'($urandom_range(1, 9)), 2, 1'($urandom_range(0, 1)));
        end

        // Reset while running drops the enable.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("runrst_en_pc", en_pc_net, 0);
        check("runrst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
